// File: rtl/writeback_stage.sv
// Y86-64 write-back stage: M->W pipeline register, register-file write ports,
// W-stage forwarding outputs, RUN/HALTED control and retired-instruction count.
module writeback_stage #(
   parameter int                DATA_W = 64,
   parameter int                REG_AW = 4,
   parameter int                CNT_W  = 32,
   parameter logic [REG_AW-1:0] RNONE  = '1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              m_valid_i,
   input  logic [3:0]        m_icode_i,
   input  logic [2:0]        m_stat_i,
   input  logic [DATA_W-1:0] m_valE_i,
   input  logic [DATA_W-1:0] m_valM_i,
   input  logic [REG_AW-1:0] m_dstE_i,
   input  logic [REG_AW-1:0] m_dstM_i,
   input  logic              dmem_error_i,
   input  logic              w_stall_i,
   input  logic              w_bubble_i,
   output logic              rf_weE_o,
   output logic [REG_AW-1:0] rf_addrE_o,
   output logic [DATA_W-1:0] rf_dataE_o,
   output logic              rf_weM_o,
   output logic [REG_AW-1:0] rf_addrM_o,
   output logic [DATA_W-1:0] rf_dataM_o,
   output logic [REG_AW-1:0] w_dstE_o,
   output logic [DATA_W-1:0] w_valE_o,
   output logic [REG_AW-1:0] w_dstM_o,
   output logic [DATA_W-1:0] w_valM_o,
   output logic [2:0]        w_stat_o,
   output logic              cpu_halted_o,
   output logic [CNT_W-1:0]  retired_o
);

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_ADR = 3'd3;

   typedef struct packed {
      logic              valid;
      logic [3:0]        icode;
      logic [2:0]        stat;
      logic [DATA_W-1:0] val_e;
      logic [DATA_W-1:0] val_m;
      logic [REG_AW-1:0] dst_e;
      logic [REG_AW-1:0] dst_m;
   } w_reg_t;

   typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

   function automatic w_reg_t bubble_entry();
      w_reg_t b;
      b       = '0;
      b.stat  = STAT_AOK;
      b.dst_e = RNONE;
      b.dst_m = RNONE;
      return b;
   endfunction

   state_t          state_q, state_d;
   w_reg_t          w_q, w_d;
   logic [CNT_W-1:0] retired_q;
   logic            ok, halt_now, we_e, we_m;

   // icode is carried in the W register for trace/debug only; no output uses it.
   logic unused_icode;
   assign unused_icode = ^w_q.icode;

   // Writes only for a real, AOK instruction while running.
   assign ok       = (state_q == RUN) && w_q.valid && (w_q.stat == STAT_AOK);
   // A faulting/halting instruction in W stops the machine at the next edge.
   assign halt_now = w_q.valid && (w_q.stat != STAT_AOK);

   // popq %rsp: on a same-id collision the M port wins and E is dropped.
   assign we_m = ok && (w_q.dst_m != RNONE);
   assign we_e = ok && (w_q.dst_e != RNONE) &&
                 !((w_q.dst_m != RNONE) && (w_q.dst_e == w_q.dst_m));

   assign rf_weE_o     = we_e;
   assign rf_addrE_o   = w_q.dst_e;
   assign rf_dataE_o   = w_q.val_e;
   assign rf_weM_o     = we_m;
   assign rf_addrM_o   = w_q.dst_m;
   assign rf_dataM_o   = w_q.val_m;
   assign w_dstE_o     = we_e ? w_q.dst_e : RNONE;
   assign w_valE_o     = w_q.val_e;
   assign w_dstM_o     = we_m ? w_q.dst_m : RNONE;
   assign w_valM_o     = w_q.val_m;
   assign w_stat_o     = w_q.stat;
   assign cpu_halted_o = (state_q == HALTED);
   assign retired_o    = retired_q;

   // Next state and next W contents. On the halting edge the W register is
   // held, so w_stat_o keeps reporting the status that stopped the machine.
   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      if (state_q == RUN) begin
         if (halt_now) begin
            state_d = HALTED;
         end else if (!w_stall_i) begin
            if (w_bubble_i) begin
               w_d = bubble_entry();
            end else begin
               w_d.valid = m_valid_i;
               w_d.icode = m_icode_i;
               w_d.stat  = dmem_error_i ? STAT_ADR : m_stat_i;
               w_d.val_e = m_valE_i;
               w_d.val_m = m_valM_i;
               w_d.dst_e = m_dstE_i;
               w_d.dst_m = m_dstM_i;
            end
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= RUN;
      else          state_q <= state_d;
   end

   // W pipeline register; reset drops any in-flight instruction.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) w_q <= bubble_entry();
      else          w_q <= w_d;
   end

   // Count an entry once, on the edge where it leaves W (not while stalled).
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)               retired_q <= '0;
      else if (ok && !w_stall_i)  retired_q <= retired_q + 1'b1;
   end

endmodule
